helper_axis_drain: RTL and testbench
====================================

// Module: helper_axis_drain
// PURPOSE
// - Test-bench AXIS sink: consumes a stream, drives input_ready with a repeatable LFSR backpressure pattern.
// - Sits at the end of a DUT output bus, alongside the inline checker that monitors the same valid/data/ready.
// - Counts transfers, flags completion, watchdog timeout and (optionally) source protocol violations.
// PARAMETERS
// - DATA_WIDTH      10       width of input_data
// - COUNT_WIDTH     32       width of count output
// - TRANSACTIONS    0        transfers before done; 0 = unlimited (never done)
// - STALL_THRESHOLD 0        0..255; ready offered when lfsr[7:0] >= STALL_THRESHOLD; 0 = never stall
// - LFSR_SEED       16'hACE1 reset value of 16-bit LFSR; must be nonzero
// - TIMEOUT_CYCLES  0        consecutive RUN cycles with input_valid=0 before timeout; 0 = watchdog disabled
// PORTS
// - clk          in   1           clock, all logic on rising edge
// - rst          in   1           synchronous, active-high reset
// - enable       in   1           1 = accept traffic; 0 = pause (ready forced low, state held)
// - input_valid  in   1           AXIS valid from source
// - input_data   in   DATA_WIDTH  AXIS data from source
// - input_ready  out  1           AXIS ready, registered
// - count        out  COUNT_WIDTH transfers accepted since reset
// - last_data    out  DATA_WIDTH  data of most recent transfer
// - done         out  1           sticky; TRANSACTIONS transfers accepted
// - timeout      out  1           sticky; watchdog expired
// - violation    out  1           sticky; protocol violation (0 unless macro enabled)
// - error        out  1           sticky; timeout | violation
// BEHAVIOUR
// - Reset: input_ready=0, count=0, last_data=0, done=timeout=violation=error=0, lfsr=LFSR_SEED, idle_cnt=0, state IDLE.
// - Transfer = input_valid & input_ready at a rising edge; count+1 (wraps mod 2^COUNT_WIDTH), last_data<=input_data.
// - FSM: IDLE -> RUN when enable=1; RUN -> IDLE when enable=0 (count, lfsr, idle_cnt held);
//   RUN -> DONE when a transfer makes count==TRANSACTIONS (TRANSACTIONS!=0); RUN -> ERROR on timeout or violation.
//   DONE and ERROR are terminal; only rst leaves them. IDLE/DONE/ERROR drive input_ready=0.
// - LFSR: Galois, taps 16'hB400, advances once per cycle in RUN only.
// - input_ready <= (next state==RUN) && (lfsr_next[7:0] >= STALL_THRESHOLD); first ready one cycle after enable sampled 1.
// - Last transfer deasserts ready on the same edge; no transfer beyond TRANSACTIONS ever accepted.
// - Watchdog: idle_cnt counts RUN cycles with input_valid=0, clears on input_valid=1; at TIMEOUT_CYCLES
//   timeout=1, error=1, -> ERROR. Own backpressure (valid=1, ready=0) never counts as idle.
// - Simultaneous: violation + final transfer same edge -> ERROR wins, done stays 0, count still increments;
//   enable falling with transfer on same edge -> transfer counted, then IDLE.
// - rst mid-operation: all registers to reset values next edge; reseeded LFSR reproduces identical ready pattern.
// CONFIGURATION
// - Macro HELPER_AXIS_DRAIN_PROTOCOL_CHECK_EN defined: in RUN, if previous cycle had valid=1, ready=0, then
//   this cycle input_valid=0 or input_data != held value -> violation=1, error=1, -> ERROR; also $isunknown(input_data)
//   at a transfer -> violation. Each violation reported once via $error.
// - Macro undefined: no checking logic, violation tied 0, error = timeout.
// TESTING
// - STALL_THRESHOLD=0, TRANSACTIONS=4, source valid=1 data 1..4 -> ready high 1 cycle after enable, 4 transfers in 4
//   consecutive cycles, count=4, last_data=4, done=1, ready=0 after.
// - STALL_THRESHOLD=128, TRANSACTIONS=100, always-valid source -> ready matches bench LFSR model cycle-by-cycle, done, count=100.
// - TIMEOUT_CYCLES=10, valid held 0 after enable -> timeout=1, error=1 after 10th idle RUN cycle; ready=0 thereafter.
// - Macro on: source drops valid while ready=0 -> violation=1, error=1 next edge; macro off: same stimulus, error stays 0.
// - rst after 3 transfers -> all outputs 0 next edge; re-enable -> ready sequence identical to first run.
// - enable=0 mid-run after 5 transfers -> ready=0 next edge, count holds 5; enable=1 -> resumes LFSR pattern where paused.

Source files
------------

// File: rtl/helper_axis_drain.sv
// helper_axis_drain
//   Test-bench AXI-Stream sink. Accepts a stream, throttles input_ready with a
//   repeatable Galois LFSR pattern, counts transfers, and flags completion,
//   watchdog timeout and (optionally) source protocol violations.
//
//   Optional feature macro: HELPER_AXIS_DRAIN_PROTOCOL_CHECK_EN
//     defined   : checks that valid/data are held stable while stalled, and that
//                 data is never unknown at a transfer
//     undefined : no checker, violation tied low, error = timeout
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   enable       in   1 = accept traffic, 0 = pause (ready low, state held)
//   input_valid  in   AXIS valid from source
//   input_data   in   AXIS data from source
//   input_ready  out  AXIS ready (registered)
//   count        out  transfers accepted since reset (wraps)
//   last_data    out  data of most recent transfer
//   done         out  sticky, TRANSACTIONS transfers accepted
//   timeout      out  sticky, watchdog expired
//   violation    out  sticky, source protocol violation
//   error        out  sticky, timeout | violation
module helper_axis_drain #(
    parameter int unsigned DATA_WIDTH      = 10,
    parameter int unsigned COUNT_WIDTH     = 32,
    parameter int unsigned TRANSACTIONS    = 0,
    parameter int unsigned STALL_THRESHOLD = 0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned TIMEOUT_CYCLES  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   input_valid,
    input  logic [DATA_WIDTH-1:0]  input_data,
    output logic                   input_ready,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0]  last_data,
    output logic                   done,
    output logic                   timeout,
    output logic                   violation,
    output logic                   error
);

    localparam logic [COUNT_WIDTH-1:0] TransCnt   = COUNT_WIDTH'(TRANSACTIONS);
    localparam logic [7:0]             StallThr   = 8'(STALL_THRESHOLD);
    localparam logic [31:0]            TimeoutCnt = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StError} state_e;

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d, lfsr_step;
    logic [31:0]            idle_cnt_q, idle_cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  last_data_q, last_data_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   error_q, error_d;
    logic                   xfer, timeout_hit, violation_hit;

    // ready_q is only ever set with next state RUN, so xfer needs no state qualifier;
    // a transfer on the edge that leaves RUN is still counted.
    assign xfer      = input_valid & ready_q;
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

`ifdef HELPER_AXIS_DRAIN_PROTOCOL_CHECK_EN
    logic                  stall_q;
    logic [DATA_WIDTH-1:0] held_q;
    logic                  violation_q;

    // A stalled beat must reappear unchanged on the next cycle.
    assign violation_hit = (state_q == StRun) &&
                           ((stall_q && (!input_valid || (input_data != held_q))) ||
                            (xfer && $isunknown(input_data)));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q     <= 1'b0;
            held_q      <= '0;
            violation_q <= 1'b0;
        end else begin
            stall_q     <= (state_q == StRun) && input_valid && !ready_q;
            held_q      <= input_data;
            violation_q <= violation_q | violation_hit;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && violation_hit && !violation_q) begin
            $error("helper_axis_drain: source protocol violation");
        end
    end
`endif

    assign violation = violation_q;
`else
    assign violation_hit = 1'b0;
    assign violation     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        timeout_hit = 1'b0;
        count_d     = xfer ? count_q + COUNT_WIDTH'(1) : count_q;
        last_data_d = xfer ? input_data : last_data_q;

        // Watchdog: only RUN cycles with no offered data count as idle.
        if (state_q == StRun) begin
            if (input_valid) begin
                idle_cnt_d = '0;
            end else if (TIMEOUT_CYCLES != 0) begin
                idle_cnt_d  = idle_cnt_q + 32'd1;
                timeout_hit = (idle_cnt_d == TimeoutCnt);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (timeout_hit || violation_hit) begin
                    state_d = StError;
                end else if ((TRANSACTIONS != 0) && xfer && (count_d == TransCnt)) begin
                    state_d = StDone;
                end else if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        // LFSR only moves while running; the pause edge consumes one value so the
        // pattern resumes with the next one rather than repeating.
        lfsr_d    = (state_q == StRun) ? lfsr_step : lfsr_q;
        ready_d   = (state_d == StRun) && (lfsr_d[7:0] >= StallThr);
        done_d    = done_q | ((state_q == StRun) && (state_d == StDone));
        timeout_d = timeout_q | timeout_hit;
        error_d   = error_q | timeout_hit | violation_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= LFSR_SEED;
            idle_cnt_q  <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            idle_cnt_q  <= idle_cnt_d;
            count_q     <= count_d;
            last_data_q <= last_data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
        end
    end

    assign input_ready = ready_q;
    assign count       = count_q;
    assign last_data   = last_data_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign error       = error_q;

endmodule

// File: tb/tb_helper_axis_drain.sv
// Self-checking bench for helper_axis_drain: randomized source, reference model
// kept as a precomputed ready pattern plus counters, scoreboard of per-cycle
// expected outputs checked by an independent monitor.
module tb_helper_axis_drain;

    localparam int unsigned DW   = 10;
    localparam int unsigned TR   = 20;
    localparam int unsigned TH   = 128;
    localparam int unsigned TO   = 10;
    localparam int          IDLE = 0, RUN = 1, DONE = 2, ERR = 3;

    logic          clk, rst, enable, input_valid;
    logic [DW-1:0] input_data;
    logic          input_ready, done, timeout, violation, error;
    logic [31:0]   count;
    logic [DW-1:0] last_data;

    helper_axis_drain #(
        .DATA_WIDTH     (DW),
        .COUNT_WIDTH    (32),
        .TRANSACTIONS   (TR),
        .STALL_THRESHOLD(TH),
        .LFSR_SEED      (16'hACE1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .input_valid(input_valid),
        .input_data (input_data),
        .input_ready(input_ready),
        .count      (count),
        .last_data  (last_data),
        .done       (done),
        .timeout    (timeout),
        .violation  (violation),
        .error      (error)
    );

    typedef struct packed {
        logic          ready;
        logic [31:0]   cnt;
        logic [DW-1:0] last;
        logic          dn;
        logic          to;
        logic          vio;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: ready offered on the k-th running cycle is pat[k].
    bit   pat[8192];

    int          m_st, k, m_idle;
    bit          m_ready, m_done, m_to, m_vio, m_stall;
    logic [31:0] m_count;
    logic [DW-1:0] m_last, m_held;
    bit          hold;
    logic [DW-1:0] hold_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model predicts outputs after the next edge.
    task automatic cyc(input bit r, input bit en, input bit v, input logic [DW-1:0] d);
        bit x, to, vio;
        int nst;
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; input_valid = v; input_data = d;
        if (r) begin
            m_st = IDLE; k = 0; m_idle = 0; m_ready = 0; m_count = 0; m_last = '0;
            m_done = 0; m_to = 0; m_vio = 0; m_stall = 0;
        end else begin
            x = v && m_ready; to = 0; vio = 0; nst = m_st;
            if (x) begin m_count = m_count + 1; m_last = d; end
            if (m_st == RUN) begin
                if (v) m_idle = 0;
                else begin m_idle++; to = (m_idle == TO); end
`ifdef HELPER_AXIS_DRAIN_PROTOCOL_CHECK_EN
                vio = m_stall && (!v || d != m_held);
`endif
                if (to || vio) nst = ERR;
                else if (x && m_count == TR) nst = DONE;
                else if (!en) nst = IDLE;
                k++;
            end else if (m_st == IDLE && en) begin
                nst = RUN;
            end
            m_stall = (m_st == RUN) && v && !m_ready;
            m_held  = d;
            m_to    = m_to | to;
            m_vio   = m_vio | vio;
            m_done  = m_done | (nst == DONE);
            m_st    = nst;
            m_ready = (nst == RUN) && pat[k];
        end
        e.ready = m_ready; e.cnt = m_count; e.last = m_last; e.dn = m_done;
        e.to = m_to; e.vio = m_vio; e.err = m_to | m_vio;
        exp_q.push_back(e);
    endtask

    // Well-behaved random source: holds a stalled beat until accepted.
    task automatic src(input bit en, input int pct);
        bit v;
        logic [DW-1:0] d;
        bit rdy_now;
        rdy_now = m_ready;
        if (hold) begin
            v = 1; d = hold_d;
        end else begin
            v = ($urandom_range(99) < pct);
            d = DW'($urandom);
        end
        cyc(1'b0, en, v, d);
        hold   = v && !rdy_now;
        hold_d = d;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("input_ready", 32'(input_ready), 32'(e.ready));
                chk("count", count, e.cnt);
                chk("last_data", 32'(last_data), 32'(e.last));
                chk("done", 32'(done), 32'(e.dn));
                chk("timeout", 32'(timeout), 32'(e.to));
                chk("violation", 32'(violation), 32'(e.vio));
                chk("error", 32'(error), 32'(e.err));
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [15:0] l;
        logic [DW-1:0] dd;
        l = 16'hACE1;
        for (int i = 0; i < 8192; i++) begin
            pat[i] = (l[7:0] >= 8'(TH));
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
        rst = 1; enable = 0; input_valid = 0; input_data = '0; hold = 0;

        // Reset state, then idle with enable low: ready must stay low.
        repeat (3) cyc(1, 0, 0, '0);
        repeat (3) cyc(0, 0, 1, 10'h155);

        // Random traffic until done, then beyond it.
        hold = 0;
        for (int c = 0; c < 600 && m_st != DONE; c++) src(1, 70);
        repeat (5) src(1, 70);

        // Reset after 3 transfers; rerun must replay the same ready pattern.
        repeat (2) cyc(1, 0, 0, '0);
        hold = 0;
        for (int c = 0; c < 300 && m_count < 3; c++) src(1, 100);
        cyc(1, 1, 1, '0);
        hold = 0;
        for (int c = 0; c < 600 && m_st != DONE; c++) src(1, 100);

        // Pause after 5 transfers, resume, finish.
        repeat (2) cyc(1, 0, 0, '0);
        hold = 0;
        for (int c = 0; c < 300 && m_count < 5; c++) src(1, 100);
        repeat (4) src(0, 100);
        for (int c = 0; c < 600 && m_st != DONE; c++) src(1, 100);

        // Watchdog: valid held low after enable.
        repeat (2) cyc(1, 0, 0, '0);
        repeat (14) cyc(0, 1, 0, '0);

        // Source drops valid while stalled.
        repeat (2) cyc(1, 0, 0, '0);
        dd = DW'($urandom);
        cyc(0, 1, 1, dd);
        for (int c = 0; c < 200 && (m_ready || m_st != RUN); c++) cyc(0, 1, 1, dd);
        cyc(0, 1, 1, dd);
        repeat (4) cyc(0, 1, 0, '0);

        repeat (2) cyc(0, 0, 0, '0);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
